instr_fetch_issue: RTL
======================

Name: instr_fetch_issue

Overview:
- Front end of the processor: drives the instruction-memory read handshake and holds the fetched word in an instruction register (IR).
- Presents the 5-bit opcode field to the control unit (CU) that decodes it.
- Accepts a branch redirect (taken flag plus target) back from execute.
- Keeps a retired-issue counter for debug.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address
- INSTR_W, 32, instruction word width
- OPC_LSB, 27, bit position of opcode field LSB; opcode = instr[OPC_LSB+4:OPC_LSB]
- RESET_PC, 0, PC value loaded on reset
- PC_INC, 4, PC increment per sequential fetch

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- imem_req  out  1  read request to instruction memory, held until accepted
- imem_addr  out  ADDR_W  read address, equals PC while imem_req=1
- imem_rdata  in  INSTR_W  returned instruction word
- imem_valid  in  1  imem_rdata valid this cycle; only meaningful while imem_req=1
- stall  in  1  downstream not ready; holds the issued instruction
- branch_taken  in  1  redirect request from execute
- branch_target  in  ADDR_W  redirect address
- instr_valid  out  1  instr/opcode/instr_pc hold a valid instruction
- instr  out  INSTR_W  IR contents
- opcode  out  5  IR opcode field to CU; 5'b00000 when instr_valid=0
- instr_pc  out  ADDR_W  address the IR was fetched from
- issue_count  out  32  number of instructions issued (accepted with stall=0)

Behaviour:
- Reset (asynchronous, active-high) sets:
  - state=BOOT, PC=RESET_PC
  - IR=0, instr_pc=0, issue_count=0
  - imem_req=0, instr_valid=0, opcode=0
- FSM states: BOOT, FETCH, ISSUE. All outputs are registered or decoded from state only; none depends combinationally on the inputs.
- BOOT: lasts exactly one cycle after rst deasserts, then moves to FETCH. imem_req=0 in BOOT.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - On imem_valid=1 with branch_taken=0: IR<=imem_rdata, instr_pc<=PC, PC<=PC+PC_INC, go to ISSUE.
  - Minimum latency is 1 cycle: data returned in the same cycle as the request appears in IR on the next edge.
  - imem_valid=0: stay in FETCH; request and address stay stable.
- ISSUE:
  - instr_valid=1, imem_req=0.
  - stall=1: hold IR, instr_pc and state; issue_count unchanged.
  - stall=0: issue_count<=issue_count+1 (wraps 2^32-1 -> 0), go to FETCH.
- Branch redirect: branch_taken is sampled only in FETCH, and in ISSUE with stall=0.
  - In ISSUE with stall=0: PC<=branch_target instead of the sequential PC; the current instruction still counts as issued.
  - In FETCH: PC<=branch_target and state stays FETCH. Any imem_valid in that same cycle is discarded (branch wins; IR unchanged). imem_addr changes to the target on the next cycle.
  - branch_taken in ISSUE while stall=1 is ignored; execute re-asserts it.
  - branch_taken in BOOT is ignored.
- PC arithmetic: modulo 2^ADDR_W; wraps from max to 0 without a flag. No alignment check on branch_target.
- opcode is gated to 0 whenever instr_valid=0, so the CU sees 00000 during BOOT and FETCH.
- Reset asserted mid-FETCH or mid-ISSUE:
  - imem_req and instr_valid drop immediately (asynchronously).
  - An imem_valid that arrives while rst=1 is ignored.

Test Plan:
- Reset/boot: assert rst, release. Required:
  - cycle 0: imem_req=0, opcode=0
  - cycle 1: imem_req=1, imem_addr=0
- Zero-wait fetch: memory returns 32'h3800_0000 (opcode 00111) with imem_valid in the same cycle as the request. Next cycle:
  - instr_valid=1, opcode=5'b00111, instr_pc=0
  - after issue, imem_addr=4
- Wait states plus stall:
  - imem_valid delayed 3 cycles: imem_req and imem_addr=4 stay stable for all 3.
  - then stall=1 for 2 cycles: instr held, issue_count stays 1; increments to 2 when stall drops.
- Branch in ISSUE: branch_taken=1, branch_target=0x40, stall=0. Required: next imem_addr=0x40, issue_count incremented.
- Branch collides with return in FETCH: imem_valid=1 and branch_taken=1 (target 0x80) in the same cycle. Required:
  - IR unchanged, state stays FETCH
  - next imem_addr=0x80, instr_valid stays 0
- Async reset mid-ISSUE: rst pulse between clock edges. Required:
  - instr_valid=0 and opcode=0 immediately
  - PC back to 0, issue_count=0

Source files
------------

// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue front end: drives the instruction-memory read
// handshake, holds the fetched word in the IR, and decodes the opcode for
// the control unit. Branch redirects from execute overwrite the PC.
module instr_fetch_issue #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned OPC_LSB  = 27,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_INC   = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [4:0]         opcode,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [31:0]        issue_count
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   ipc_q, ipc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [31:0]         cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                vld_q, vld_d;

    // Next-state: branch wins over a same-cycle memory return in FETCH;
    // branch only lands in ISSUE when the instruction actually leaves.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (branch_taken) begin
                    pc_d = branch_target;
                end else if (imem_valid) begin
                    ir_d    = imem_rdata;
                    ipc_d   = pc_q;
                    pc_d    = pc_q + ADDR_W'(PC_INC);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_FETCH;
                    if (branch_taken) pc_d = branch_target;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
        // Handshake outputs are registered copies of the next state, so
        // nothing seen by memory or the CU depends combinationally on inputs.
        req_d = (state_d == S_FETCH);
        vld_d = (state_d == S_ISSUE);
    end

    // State and datapath registers; reset drops req/valid immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q    <= ADDR_W'(RESET_PC);
            ipc_q   <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            vld_q   <= vld_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = vld_q;
    assign instr       = ir_q;
    assign instr_pc    = ipc_q;
    assign issue_count = cnt_q;
    // CU sees a NOP-like 00000 whenever no instruction is held.
    assign opcode      = vld_q ? ir_q[OPC_LSB+4:OPC_LSB] : 5'b00000;

endmodule
